load_store_unit: RTL and testbench

//  Sits between the RISC-V core datapath (ALU address, rs2 store data) and a valid/ready data bus.

---
 rtl/load_store_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns core load/store requests into valid/ready bus beats, stalls the core until done.
// Build option LSU_MISALIGN_SPLIT_EN: split word-crossing H/W accesses into two beats instead of faulting.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        misalign_fault,
  output logic        bus_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_R, REQ2, WAIT_R2, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d, be2_q, be2_d;
  logic [31:0] wdata_q, wdata_d, wdata2_q, wdata2_d;
  logic [31:0] rword1_q, rword1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        split_q, split_d;
  logic        bfault_q, bfault_d;
  logic        mfault_q, mfault_d;

  logic [7:0]  req_be8;
  logic [63:0] req_wdata64;
  logic        illegal;
  logic        misalign_stop;
  logic        waiting;
  logic        timeout;

  // Pick the addressed byte/half out of a two-word window and extend it per funct3.
  function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] w;
    w = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_be8 = 8'h01 << req_addr[1:0];
      2'b01:   req_be8 = 8'h03 << req_addr[1:0];
      default: req_be8 = 8'h0F << req_addr[1:0];
    endcase
    req_wdata64 = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    illegal     = (req_funct3 inside {3'b011, 3'b110, 3'b111}) || (req_we && req_funct3[2]);
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign_stop = 1'b0;
`else
  assign misalign_stop = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`endif

  assign waiting = (state_q == REQ) || (state_q == WAIT_R) || (state_q == REQ2) || (state_q == WAIT_R2);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    be2_d    = be2_q;
    wdata_d  = wdata_q;
    wdata2_d = wdata2_q;
    rword1_d = rword1_q;
    rdata_d  = rdata_q;
    split_d  = split_q;
    bfault_d = bfault_q;
    mfault_d = mfault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_d  = DONE;
            bfault_d = 1'b1;
            rdata_d  = '0;
          end else if (misalign_stop) begin
            state_d  = DONE;
            mfault_d = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d  = REQ;
            we_d     = req_we;
            f3_d     = req_funct3;
            off_d    = req_addr[1:0];
            addr_d   = {req_addr[31:2], 2'b00};
            be_d     = req_be8[3:0];
            be2_d    = req_be8[7:4];
            wdata_d  = req_wdata64[31:0];
            wdata2_d = req_wdata64[63:32];
            split_d  = |req_be8[7:4];
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          if (!we_q) begin
            state_d = WAIT_R;
          end else if (split_q) begin
            state_d = REQ2;
            addr_d  = addr_q + 32'd4;
            be_d    = be2_q;
            wdata_d = wdata2_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_R: begin
        // The beat-1 word is parked until beat 2 returns so both are extracted together.
        if (bus_rvalid) begin
          if (split_q) begin
            state_d  = REQ2;
            rword1_d = bus_rdata;
            addr_d   = addr_q + 32'd4;
            be_d     = be2_q;
            wdata_d  = wdata2_q;
          end else begin
            state_d = DONE;
            rdata_d = load_extend({32'h0, bus_rdata}, off_q, f3_q);
          end
        end
      end
      REQ2: begin
        if (bus_ready) state_d = we_q ? DONE : WAIT_R2;
      end
      WAIT_R2: begin
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = load_extend({bus_rdata, rword1_q}, off_q, f3_q);
        end
      end
      DONE: begin
        state_d  = IDLE;
        bfault_d = 1'b0;
        mfault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (waiting && state_d == state_q && timeout) begin
      state_d  = DONE;
      bfault_d = 1'b1;
      rdata_d  = '0;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + 32'd1;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      be2_q    <= '0;
      wdata_q  <= '0;
      wdata2_q <= '0;
      rword1_q <= '0;
      rdata_q  <= '0;
      split_q  <= 1'b0;
      bfault_q <= 1'b0;
      mfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      be2_q    <= be2_d;
      wdata_q  <= wdata_d;
      wdata2_q <= wdata2_d;
      rword1_q <= rword1_d;
      rdata_q  <= rdata_d;
      split_q  <= split_d;
      bfault_q <= bfault_d;
      mfault_q <= mfault_d;
    end
  end

  assign stall          = req_valid && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign bus_valid      = (state_q == REQ) || (state_q == REQ2);
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_be         = be_q;
  assign bus_wdata      = wdata_q;
  assign rdata_out      = rdata_q;
  assign bus_fault      = bfault_q;
  assign misalign_fault = mfault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small bus responder (ready on valid, rvalid two cycles after accept).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misalign_fault, bus_fault;
  logic [31:0] rdata_out;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;

  int          nbeats, nstall, nvalid;
  logic        got_done, d_bf, d_mf, d_bv;
  logic [31:0] d_rdata;
  logic [31:0] b_addr[2], b_wd[2];
  logic [3:0]  b_be[2];
  logic        b_we[2];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata_out(rdata_out), .done(done),
    .misalign_fault(misalign_fault), .bus_fault(bus_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one request and act as the bus until done (or a 40-cycle budget runs out).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                        input logic ready_en);
    int   cd;
    logic pend;
    int   nrd;
    cd = 0; pend = 1'b0; nrd = 0;
    nbeats = 0; nstall = 0; nvalid = 0; got_done = 1'b0;
    d_rdata = '0; d_bf = 1'b0; d_mf = 1'b0; d_bv = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      if (done) begin
        got_done  = 1'b1;
        d_rdata   = rdata_out;
        d_bf      = bus_fault;
        d_mf      = misalign_fault;
        d_bv      = bus_valid;
        req_valid = 1'b0;
      end else begin
        if (stall) nstall++;
        if (pend) begin
          cd--;
          if (cd == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = (nrd == 0) ? w0 : w1;
            nrd++;
            pend = 1'b0;
          end
        end
        if (bus_valid) begin
          nvalid++;
          if (ready_en) begin
            bus_ready = 1'b1;
            if (nbeats < 2) begin
              b_addr[nbeats] = bus_addr;
              b_be[nbeats]   = bus_be;
              b_wd[nbeats]   = bus_wdata;
              b_we[nbeats]   = bus_we;
            end
            nbeats++;
            if (!we) begin
              pend = 1'b1;
              cd   = 2;
            end
          end
        end
      end
      @(posedge clk); #1;
    end
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    req_valid  = 1'b0;
    check("done_within_budget", got_done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_faults", {bus_fault, misalign_fault}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW aligned
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("lw_rdata", d_rdata, 32'hDEAD_BEEF);
    check("lw_stall_cycles", nstall, 4);
    check("lw_beats", nbeats, 1);
    check("lw_addr", b_addr[0], 32'h0000_0100);
    check("lw_be", b_be[0], 4'b1111);
    check("lw_we", b_we[0], 0);
    check("lw_faults", {d_bf, d_mf}, 0);
    check("lw_rdata_held", rdata_out, 32'hDEAD_BEEF);
    check("lw_done_pulse", done, 0);

    // Byte loads at lane 3
    access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_EE11, 32'h0, 1'b1);
    check("lb_be", b_be[0], 4'b1000);
    check("lb_addr", b_addr[0], 32'h0000_0100);
    check("lb_rdata", d_rdata, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_EE11, 32'h0, 1'b1);
    check("lbu_rdata", d_rdata, 32'h0000_0080);

    // Halfword loads
    access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234, 32'h0, 1'b1);
    check("lh_be", b_be[0], 4'b1100);
    check("lh_rdata", d_rdata, 32'hFFFF_8001);
    access(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h1234_F00D, 32'h0, 1'b1);
    check("lhu_rdata", d_rdata, 32'h0000_F00D);

    // Stores
    access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0, 32'h0, 1'b1);
    check("sh_addr", b_addr[0], 32'h0000_0200);
    check("sh_be", b_be[0], 4'b1100);
    check("sh_wdata", b_wd[0], 32'h1234_0000);
    check("sh_we", b_we[0], 1);
    check("sh_stall_cycles", nstall, 2);
    check("sh_bus_fault", d_bf, 0);
    access(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 32'h0, 32'h0, 1'b1);
    check("sb_be", b_be[0], 4'b0010);
    check("sb_wdata", b_wd[0], 32'h0000_AB00);
    access(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1);
    check("sw_be", b_be[0], 4'b1111);
    check("sw_wdata", b_wd[0], 32'hCAFE_F00D);

    // Misaligned word
`ifdef LSU_MISALIGN_SPLIT_EN
    access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h4433_2211, 32'h8877_6655, 1'b1);
    check("split_beats", nbeats, 2);
    check("split_addr0", b_addr[0], 32'h0000_0100);
    check("split_be0", b_be[0], 4'b1110);
    check("split_addr1", b_addr[1], 32'h0000_0104);
    check("split_be1", b_be[1], 4'b0001);
    check("split_rdata", d_rdata, 32'h5544_3322);
    check("split_mfault", d_mf, 0);
`else
    access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h4433_2211, 32'h0, 1'b1);
    check("mis_mfault", d_mf, 1);
    check("mis_bus_valid_cycles", nvalid, 0);
    check("mis_rdata_zero", d_rdata, 0);
    check("mis_bus_fault", d_bf, 0);
    access(1'b1, 3'b001, 32'h0000_0201, 32'h0000_5678, 32'h0, 32'h0, 1'b1);
    check("mis_sh_mfault", d_mf, 1);
    check("mis_sh_bus_valid_cycles", nvalid, 0);
`endif

    // Illegal funct3
    access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b1);
    check("ill_load_bfault", d_bf, 1);
    check("ill_load_bus_valid_cycles", nvalid, 0);
    access(1'b1, 3'b100, 32'h0000_0100, 32'h0000_00FF, 32'h0, 32'h0, 1'b1);
    check("ill_store_bfault", d_bf, 1);
    check("ill_store_bus_valid_cycles", nvalid, 0);

    // Timeout with ready held low
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b0);
    check("to_bfault", d_bf, 1);
    check("to_req_cycles", nvalid, 4);
    check("to_bus_valid_at_done", d_bv, 0);
    check("to_rdata_zero", d_rdata, 0);

    // Async reset in REQ, then in WAIT_R
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
    @(posedge clk); #1;
    check("rst_req_bus_valid_before", bus_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_req_bus_valid", bus_valid, 0);
    check("rst_req_bus_be", bus_be, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    check("rst_wr_stall_before", stall, 1);
    #3 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_wr_stall", stall, 0);
    check("rst_wr_done", done, 0);
    check("rst_wr_bus_valid", bus_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b1);
    check("post_rst_lw_rdata", d_rdata, 32'h0BAD_F00D);
    check("post_rst_lw_stall_cycles", nstall, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
